// File: rtl/audio_mixer_nch.sv
// N-channel audio mixer: one time-shared adder over NUM_CH unsigned channels,
// per-channel shift gain, output shift with saturation and a linear soft-mute ramp.
//
// state | meaning
// IDLE  | waiting for ce_sample; the level ramp and audio_out hold
// ACCUM | adding one snapshotted channel per cycle into acc
// SCALE | saturate the shifted sum, step the mute level, form the scaled product
// OUT   | present the product on audio_out with a one-cycle audio_valid pulse

module audio_mixer_nch #(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 16,
  parameter int OUT_SH = 5,
  parameter int RAMP_W = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_sample,
  input  logic [NUM_CH*IN_W-1:0] ch_in,
  input  logic [NUM_CH*2-1:0]    ch_gain,
  input  logic                   mute,
  output logic [OUT_W-1:0]       audio_out,
  output logic                   audio_valid,
  output logic                   busy,
  output logic                   overrun
);

  // Three extra bits cover the maximum gain shift, clog2 covers the channel count.
  localparam int ACC_W = IN_W + 3 + $clog2(NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SC_W  = ACC_W + OUT_SH;
  localparam int CMP_W = (SC_W > OUT_W) ? SC_W : OUT_W;
  localparam int PW    = OUT_W + RAMP_W + 1;

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_CH - 1);
  localparam logic [RAMP_W:0]   LEVEL_FULL = {1'b1, {RAMP_W{1'b0}}};
  localparam logic [RAMP_W:0]   LEVEL_ZERO = '0;
  localparam logic [CMP_W-1:0]  SAT_MAX    = CMP_W'({OUT_W{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CH*IN_W-1:0]  snap_ch_q, snap_ch_d;
  logic [NUM_CH*2-1:0]     snap_gain_q, snap_gain_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [RAMP_W:0]         level_q, level_d;
  logic [OUT_W-1:0]        prod_q, prod_d;
  logic [OUT_W-1:0]        audio_out_q, audio_out_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [IN_W-1:0]         ch_sel;
  logic [1:0]              gain_sel;
  logic [ACC_W-1:0]        addend;
  logic [SC_W-1:0]         scaled;
  logic [CMP_W-1:0]        scaled_ext;
  logic [OUT_W-1:0]        sat;
  logic [RAMP_W:0]         level_next;

  always_comb begin
    ch_sel   = snap_ch_q[int'(idx_q)*IN_W +: IN_W];
    gain_sel = snap_gain_q[int'(idx_q)*2 +: 2];
    addend   = ACC_W'(ch_sel) << gain_sel;
  end

  always_comb begin
    scaled     = SC_W'(acc_q) << OUT_SH;
    scaled_ext = CMP_W'(scaled);
    sat        = (scaled_ext > SAT_MAX) ? {OUT_W{1'b1}} : scaled_ext[OUT_W-1:0];
  end

  // The ramp moves one step per output sample and clamps at both ends.
  always_comb begin
    level_next = level_q;
    if (mute) begin
      if (level_q != LEVEL_ZERO) level_next = level_q - (RAMP_W+1)'(1);
    end else begin
      if (level_q != LEVEL_FULL) level_next = level_q + (RAMP_W+1)'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_ch_d   = snap_ch_q;
    snap_gain_d = snap_gain_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    level_d     = level_q;
    prod_d      = prod_q;
    audio_out_d = audio_out_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;

    // A strobe arriving mid-mix is dropped but remembered.
    if (ce_sample && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (ce_sample) begin
          snap_ch_d   = ch_in;
          snap_gain_d = ch_gain;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + addend;
        if (idx_q == IDX_LAST) begin
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SCALE: begin
        level_d = level_next;
        prod_d  = OUT_W'((PW'(sat) * PW'(level_next)) >> RAMP_W);
        state_d = S_OUT;
      end
      S_OUT: begin
        audio_out_d = prod_q;
        valid_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      snap_ch_q   <= '0;
      snap_gain_q <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      level_q     <= LEVEL_FULL;
      prod_q      <= '0;
      audio_out_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_ch_q   <= snap_ch_d;
      snap_gain_q <= snap_gain_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      prod_q      <= prod_d;
      audio_out_q <= audio_out_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Directed bench for audio_mixer_nch (3 channels, defaults); a reference model
// pushes expected samples on each accepted strobe and a monitor pops them on audio_valid.

module tb_audio_mixer_nch;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_sample;
  logic [23:0] ch_in;
  logic [5:0]  ch_gain;
  logic        mute;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        busy;
  logic        overrun;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          valid_count  = 0;
  int          model_level  = 16;
  int          lat;
  int          vc_before;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  audio_mixer_nch dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_sample   (ce_sample),
    .ch_in       (ch_in),
    .ch_gain     (ch_gain),
    .mute        (mute),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shifted sum, saturate, step level, scale.
  function automatic logic [15:0] model_mix(input logic [23:0] ch, input logic [5:0] g, input logic m);
    longint sum = 0;
    longint sat;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] s;
      logic [1:0] gs;
      s   = ch[k*8 +: 8];
      gs  = g[k*2 +: 2];
      sum += longint'(s) * (longint'(1) << gs);
    end
    sat = sum * 32;
    if (sat > 65535) sat = 65535;
    if (m) begin
      if (model_level > 0) model_level--;
    end else begin
      if (model_level < 16) model_level++;
    end
    return 16'((sat * model_level) / 16);
  endfunction

  always @(negedge clk_sys) begin
    if (!reset && audio_valid) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        tests_run++;
        assert (exp_q.size() != 0) else begin
          tests_failed++;
          $error("FAIL sb_unexpected_valid: observed pulse with audio_out %0h expected no pulse", audio_out);
        end
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_sample", 32'(audio_out), 32'(mon_exp));
      end
    end
  end

  // Leaves the bench at the negedge just after the strobe edge.
  task automatic start_mix(input bit accepted);
    @(negedge clk_sys);
    ce_sample = 1'b1;
    if (accepted) exp_q.push_back(model_mix(ch_in, ch_gain, mute));
    @(negedge clk_sys);
    ce_sample = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!audio_valid && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
  endtask

  task automatic set_basic();
    ch_in   = {8'h10, 8'h20, 8'h08};
    ch_gain = {2'd0, 2'd2, 2'd1};
  endtask

  initial begin
    reset     = 1'b1;
    ce_sample = 1'b0;
    mute      = 1'b0;
    ch_in     = '0;
    ch_gain   = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_audio_out", 32'(audio_out), 32'h0);
    check("rst_valid", 32'(audio_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;

    // basic mix, latency, pulse width, hold
    set_basic();
    start_mix(1'b1);
    check("busy_after_strobe", 32'(busy), 32'h1);
    wait_valid(lat);
    check("basic_latency", 32'(lat), 32'd5);
    check("basic_value", 32'(audio_out), 32'h1400);
    check("busy_in_valid_cycle", 32'(busy), 32'h0);
    @(negedge clk_sys);
    check("valid_one_cycle", 32'(audio_valid), 32'h0);
    repeat (3) @(negedge clk_sys);
    check("hold_value", 32'(audio_out), 32'h1400);

    // saturation and zero
    ch_in = 24'hFFFFFF; ch_gain = 6'b111111;
    start_mix(1'b1);
    wait_valid(lat);
    check("sat_value", 32'(audio_out), 32'hFFFF);
    repeat (2) @(negedge clk_sys);
    ch_in = '0;
    start_mix(1'b1);
    wait_valid(lat);
    check("zero_value", 32'(audio_out), 32'h0);
    repeat (2) @(negedge clk_sys);

    // back-to-back: strobe in the valid cycle is accepted
    set_basic();
    start_mix(1'b1);
    wait_valid(lat);
    ce_sample = 1'b1;
    exp_q.push_back(model_mix(ch_in, ch_gain, mute));
    @(negedge clk_sys);
    ce_sample = 1'b0;
    wait_valid(lat);
    check("b2b_latency", 32'(lat), 32'd5);
    check("b2b_overrun", 32'(overrun), 32'h0);
    repeat (2) @(negedge clk_sys);

    // soft mute ramp down to silence and back up
    mute = 1'b1;
    for (int i = 0; i < 17; i++) begin
      start_mix(1'b1);
      wait_valid(lat);
      if (i == 0) check("mute_first", 32'(audio_out), 32'h12C0);
      if (i == 1) check("mute_second", 32'(audio_out), 32'h1180);
      if (i == 15) check("mute_16th", 32'(audio_out), 32'h0);
      repeat (3) @(negedge clk_sys);
    end
    check("mute_stays_zero", 32'(audio_out), 32'h0);
    mute = 1'b0;
    for (int i = 0; i < 16; i++) begin
      start_mix(1'b1);
      wait_valid(lat);
      if (i == 0) check("unmute_first", 32'(audio_out), 32'h140);
      repeat (3) @(negedge clk_sys);
    end
    check("unmute_full", 32'(audio_out), 32'h1400);

    // reverse direction mid-ramp
    mute = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_mix(1'b1);
      wait_valid(lat);
      repeat (2) @(negedge clk_sys);
    end
    check("toggle_low", 32'(audio_out), 32'h1040);
    mute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_mix(1'b1);
      wait_valid(lat);
      if (i == 0) check("toggle_reverse", 32'(audio_out), 32'h1180);
      repeat (2) @(negedge clk_sys);
    end
    check("toggle_full", 32'(audio_out), 32'h1400);

    // overrun and snapshot
    set_basic();
    vc_before = valid_count;
    start_mix(1'b1);
    ch_in = 24'h7F7F7F;
    @(negedge clk_sys);
    ce_sample = 1'b1;
    @(negedge clk_sys);
    ce_sample = 1'b0;
    wait_valid(lat);
    check("snapshot_value", 32'(audio_out), 32'h1400);
    repeat (10) @(negedge clk_sys);
    check("overrun_one_pulse", 32'(valid_count - vc_before), 32'd1);
    check("overrun_set", 32'(overrun), 32'h1);
    set_basic();
    start_mix(1'b1);
    wait_valid(lat);
    check("overrun_sticky", 32'(overrun), 32'h1);
    repeat (2) @(negedge clk_sys);

    // reset during accumulation
    start_mix(1'b0);
    reset = 1'b1;
    #1;
    check("midrst_audio_out", 32'(audio_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(audio_valid), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    model_level = 16;
    vc_before = valid_count;
    repeat (10) @(negedge clk_sys);
    check("midrst_no_pulse", 32'(valid_count - vc_before), 32'd0);
    start_mix(1'b1);
    wait_valid(lat);
    check("postrst_latency", 32'(lat), 32'd5);
    check("postrst_value", 32'(audio_out), 32'h1400);

    repeat (3) @(negedge clk_sys);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_mixer_nch.md
Name: audio_mixer_nch

Overview:
- Parametrised N-channel audio mixer replacing the fixed three-channel adder that feeds AUDIO_L/AUDIO_R in the arcade top level.
- Time-multiplexes one adder over NUM_CH unsigned channels, applies a per-channel 2-bit shift gain, then an output shift with saturation.
- Applies a soft mute: a linear ramp driven by the pause/mute input instead of a hard cut.
- Sits between the core's sound outputs and the top-level audio ports; runs in clk_sys with a sample strobe.

Parameters:
- NUM_CH, 3, number of input channels (1..16)
- IN_W, 8, width of each unsigned channel sample
- OUT_W, 16, output sample width (unsigned)
- OUT_SH, 5, left shift applied to the channel sum before saturation
- RAMP_W, 4, soft-mute ramp resolution; the ramp takes 2^RAMP_W output samples

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_sample  in  1  one-cycle strobe requesting a new mix
- ch_in  in  NUM_CH*IN_W  packed channel samples; channel k occupies [k*IN_W +: IN_W]
- ch_gain  in  NUM_CH*2  packed per-channel left shift 0..3; channel k occupies [k*2 +: 2]
- mute  in  1  level target: 1 = ramp down to silence, 0 = ramp up to full
- audio_out  out  OUT_W  mixed, saturated, level-scaled sample
- audio_valid  out  1  one-cycle pulse when audio_out updates
- busy  out  1  high while a mix is in progress (state != IDLE)
- overrun  out  1  sticky; set when ce_sample arrives while busy

Behaviour:
- Reset (async): state=IDLE, audio_out=0, audio_valid=0, busy=0, overrun=0, acc=0, channel index=0, level=2^RAMP_W (full scale). Reset mid-mix aborts the mix immediately; no valid pulse follows.
- Widths:
  - ACC_W = IN_W + 3 + clog2(NUM_CH); the accumulator never wraps.
  - Scaled sum uses ACC_W+OUT_SH bits.
  - level uses RAMP_W+1 bits.
- State machine:
  - IDLE: on ce_sample, snapshot ch_in and ch_gain into internal registers, acc<=0, idx<=0, go to ACCUM. Later changes to ch_in or ch_gain do not affect this mix.
  - ACCUM: each cycle acc <= acc + (zero-extended snap[idx] << gain[idx]); idx++. After idx = NUM_CH-1 is added, go to SCALE. This takes exactly NUM_CH cycles.
  - SCALE:
    - sat = min(acc << OUT_SH, 2^OUT_W - 1).
    - level_next = mute ? max(level-1, 0) : min(level+1, 2^RAMP_W).
    - level <= level_next.
    - prod = (sat * level_next) >> RAMP_W, truncated.
    - Go to OUT.
  - OUT: audio_out <= prod, audio_valid <= 1 for exactly one cycle, state <= IDLE.
- Latency: with ce_sample sampled at edge E, audio_valid is high in the cycle after edge E+NUM_CH+2 and audio_out holds the new value from that edge on.
- busy is high from edge E through the OUT cycle. It is low in the cycle audio_valid is high, and a ce_sample in that cycle is accepted.
- A ce_sample while busy is dropped, does not disturb the current mix, and sets overrun. Only reset clears overrun.
- The mute level steps by one per output sample, never per clock, and saturates at 0 and 2^RAMP_W. Toggling mute mid-ramp reverses direction from the current level.
- At level 2^RAMP_W, audio_out == sat exactly. At level 0, audio_out == 0.
- audio_out holds its value between valid pulses.
- NUM_CH=1 must work: ACCUM lasts one cycle.

Test Plan (NUM_CH=3, IN_W=8, OUT_W=16, OUT_SH=5, RAMP_W=4):
1. Basic mix: ch = {0x08 g1, 0x20 g2, 0x10 g0}, mute=0, ce_sample pulse -> sum 0xA0; audio_out=0x1400; audio_valid exactly 5 cycles after the strobe edge, 1 cycle wide.
2. Saturation: all channels 0xFF, gain 3 -> acc=0x17E8, audio_out=0xFFFF; all inputs 0 -> audio_out=0x0000.
3. Soft mute: scenario 1 inputs, ce_sample every 8 cycles, assert mute -> outputs 0x12C0, 0x1180, ... decreasing by 0x140 per sample, 16th sample=0x0000 and stays 0. Release mute -> rises by 0x140 per sample back to 0x1400 after 16 samples.
4. Overrun/snapshot: second ce_sample 2 cycles after the first, and ch_in changed in between -> first result still uses snapshot values (0x1400), second strobe dropped (one valid pulse only), overrun=1 and stays set.
5. Back-to-back: ce_sample in the audio_valid cycle -> accepted, next valid 5 cycles later, overrun stays 0.
6. Reset: assert reset during ACCUM -> all outputs 0 at once, no valid pulse; after release, level full, scenario 1 gives 0x1400.
